// File: rtl/spi_flash_prog_seq.sv
// spi_flash_prog_seq: turns a page-program or sector-erase request into the
// WREN / operation / RDSR-poll command sequence driven into spi_flash_cmd.
module spi_flash_prog_seq #(
    parameter logic [3:0]  CMD_WREN = 4'd1,
    parameter logic [3:0]  CMD_SE   = 4'd6,
    parameter logic [3:0]  CMD_RDSR = 4'd3,
    parameter logic [3:0]  CMD_PP   = 4'd9,
    parameter logic [15:0] POLL_GAP = 16'd100,
    parameter logic [19:0] POLL_MAX = 20'd100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_op,
    input  logic [23:0] i_req_addr,
    input  logic [8:0]  i_req_len,
    output logic        o_src_rd,
    input  logic [7:0]  i_src_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_status,
    output logic [3:0]  o_cmd,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ack,
    output logic [23:0] o_addr,
    output logic [8:0]  o_byte_size,
    input  logic        i_data_req,
    output logic [7:0]  o_data_in,
    input  logic [7:0]  i_data_out,
    input  logic        i_data_valid
);
    typedef enum logic [2:0] {IDLE, WREN, OP, GAP, RDSR, CHECK, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  len_q, len_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [23:0] cmd_addr_q, cmd_addr_d;
    logic [8:0]  size_q, size_d;
    logic [15:0] gap_q, gap_d;
    logic [19:0] poll_q, poll_d;
    logic [8:0]  src_cnt_q, src_cnt_d;
    logic [7:0]  status_q, status_d;
    logic        in_cmd, acked, prog, reject;
    logic [9:0]  page_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            addr_q      <= 24'd0;
            len_q       <= 9'd0;
            cmd_q       <= 4'd0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= 24'd0;
            size_q      <= 9'd0;
            gap_q       <= 16'd0;
            poll_q      <= 20'd0;
            src_cnt_q   <= 9'd0;
            status_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            size_q      <= size_d;
            gap_q       <= gap_d;
            poll_q      <= poll_d;
            src_cnt_q   <= src_cnt_d;
            status_q    <= status_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        size_d      = size_q;
        poll_d      = poll_q;
        status_d    = status_q;
        gap_d       = (state_q == GAP) ? gap_q + 16'd1 : 16'd0;
        in_cmd      = (state_q == WREN) || (state_q == OP) || (state_q == RDSR);
        acked       = in_cmd && cmd_valid_q && i_cmd_ack;
        prog        = (state_q == OP) && !op_q;
        o_src_rd    = prog && i_data_req && (src_cnt_q < len_q);
        src_cnt_d   = (state_q == IDLE) ? 9'd0 : src_cnt_q + {8'd0, o_src_rd};
        page_end    = {2'b00, i_req_addr[7:0]} + {1'b0, i_req_len};
        reject      = !i_req_op && (i_req_len == 9'd0 || i_req_len > 9'd256 || page_end > 10'd256);
        // Commands rise one cycle after state entry, guaranteeing a low cycle between commands.
        if (in_cmd && !cmd_valid_q) begin
            cmd_valid_d = 1'b1;
            cmd_d       = (state_q == WREN) ? CMD_WREN : (state_q == RDSR) ? CMD_RDSR : op_q ? CMD_SE : CMD_PP;
            cmd_addr_d  = (state_q != OP) ? 24'd0 : op_q ? {addr_q[23:12], 12'h000} : addr_q;
            size_d      = (state_q == RDSR) ? 9'd1 : prog ? len_q : 9'd0;
        end else if (acked) begin
            cmd_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: if (i_req_valid) begin
                op_d    = i_req_op;
                addr_d  = i_req_addr;
                len_d   = i_req_len;
                state_d = reject ? ERR : WREN;
            end
            WREN: if (acked) state_d = OP;
            OP: if (acked) begin
                poll_d  = 20'd0;
                state_d = GAP;
            end
            GAP: if (gap_q + 16'd1 >= POLL_GAP) state_d = RDSR;
            RDSR: begin
                if (i_data_valid) status_d = i_data_out;
                if (acked) begin
                    poll_d  = (poll_q == 20'hFFFFF) ? poll_q : poll_q + 20'd1;
                    state_d = CHECK;
                end
            end
            CHECK: state_d = !status_q[0] ? DONE : (poll_q == POLL_MAX) ? ERR : GAP;
            default: state_d = IDLE;
        endcase
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_err       = (state_q == ERR);
    assign o_status    = status_q;
    assign o_cmd       = cmd_q;
    assign o_cmd_valid = cmd_valid_q;
    assign o_addr      = cmd_addr_q;
    assign o_byte_size = size_q;
    assign o_data_in   = prog ? i_src_data : 8'h00;
endmodule

// File: tb/tb_spi_flash_prog_seq.sv
// tb_spi_flash_prog_seq: directed and random requests against a stub of
// spi_flash_cmd, checked against a request-level model of the command sequence.
module tb_spi_flash_prog_seq;
    localparam logic [3:0] C_WREN = 4'd1;
    localparam logic [3:0] C_SE   = 4'd6;
    localparam logic [3:0] C_RDSR = 4'd3;
    localparam logic [3:0] C_PP   = 4'd9;
    localparam int PMAX = 5;
    localparam int PGAP = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        i_req_op = 1'b0;
    logic [23:0] i_req_addr = 24'd0;
    logic [8:0]  i_req_len = 9'd0;
    logic [7:0]  i_src_data = 8'd0;
    logic        i_cmd_ack = 1'b0;
    logic        i_data_req = 1'b0;
    logic [7:0]  i_data_out = 8'd0;
    logic        i_data_valid = 1'b0;
    logic        o_req_ready, o_src_rd, o_busy, o_done, o_err, o_cmd_valid;
    logic [7:0]  o_status, o_data_in;
    logic [3:0]  o_cmd;
    logic [23:0] o_addr;
    logic [8:0]  o_byte_size;

    always #5 clk = ~clk;

    spi_flash_prog_seq #(.POLL_MAX(20'd5)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len),
        .o_src_rd(o_src_rd), .i_src_data(i_src_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_status(o_status),
        .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid), .i_cmd_ack(i_cmd_ack),
        .o_addr(o_addr), .o_byte_size(o_byte_size),
        .i_data_req(i_data_req), .o_data_in(o_data_in),
        .i_data_out(i_data_out), .i_data_valid(i_data_valid)
    );

    int n_cmp = 0, n_bad = 0;
    int act = 0, cnt = 0, dly = 0, npulse = 0, pulses = 0;
    bit src_pend = 0, cap_pend = 0;
    logic [3:0]  cur_cmd = 4'd0;
    logic [23:0] cur_addr = 24'd0;
    logic [8:0]  cur_size = 9'd0;
    int cmd_log[$], addr_log[$], size_log[$], gap_log[$];
    logic [7:0] cap_log[$];
    int idle_run = 0, n_src = 0, n_done = 0, n_err = 0, unstable = 0, src_idx = 0, rd_i = 0, st_at_op = -1;
    logic [7:0] src_mem [256];
    logic [7:0] stat_busy = 8'h01, stat_fin = 8'h00, exp_status = 8'h00;
    int n_busy = 0, extra = 0, ack_dly = 20;
    logic [31:0] u1, u2, u3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // spi_flash_cmd stub: acks each command after a delay, requests program bytes,
    // returns scripted status bytes, and logs everything the DUT issues.
    initial forever begin
        @(negedge clk);
        i_cmd_ack = 1'b0;
        i_data_req = 1'b0;
        i_data_valid = 1'b0;
        if (!rst_n) begin
            act = 0;
            src_pend = 0;
            cap_pend = 0;
        end else begin
            if (o_done) n_done++;
            if (o_err) n_err++;
            if (src_pend) begin
                i_src_data = src_mem[src_idx % 256];
                src_idx++;
                cap_pend = 1;
            end
            src_pend = 0;
            if (!o_cmd_valid) idle_run++;
            else if (act == 0) begin
                act = 1;
                cnt = 0;
                cur_cmd = o_cmd;
                cur_addr = o_addr;
                cur_size = o_byte_size;
                cmd_log.push_back(o_cmd);
                addr_log.push_back(o_addr);
                size_log.push_back(o_byte_size);
                gap_log.push_back(idle_run);
                npulse = (o_cmd == C_PP) ? o_byte_size + extra : 0;
                pulses = 0;
                dly = (2 * npulse + 3 > ack_dly) ? 2 * npulse + 3 : ack_dly;
            end
            if (act != 0) begin
                if (!o_cmd_valid || o_cmd !== cur_cmd || o_addr !== cur_addr || o_byte_size !== cur_size) unstable++;
                cnt++;
                if (pulses < npulse && cnt % 2 == 1) begin
                    i_data_req = 1'b1;
                    pulses++;
                end
                if (cur_cmd == C_RDSR && cnt == dly - 1) begin
                    i_data_valid = 1'b1;
                    i_data_out = (rd_i < n_busy) ? stat_busy : stat_fin;
                    rd_i++;
                end
                if (cur_cmd != C_RDSR && cnt == 1) begin
                    i_data_valid = 1'b1;
                    i_data_out = 8'hEE;
                end
                if (cnt == dly) begin
                    i_cmd_ack = 1'b1;
                    act = 0;
                    idle_run = 0;
                    if (cur_cmd == C_PP || cur_cmd == C_SE) st_at_op = int'(o_status);
                end
            end
            #1;
            if (o_src_rd) begin
                n_src++;
                src_pend = 1;
            end
            if (cap_pend) begin
                cap_log.push_back(o_data_in);
                cap_pend = 0;
            end
        end
    end

    task automatic clear_logs();
        cmd_log.delete(); addr_log.delete(); size_log.delete(); gap_log.delete(); cap_log.delete();
        n_src = 0; n_done = 0; n_err = 0; unstable = 0; src_idx = 0; rd_i = 0; st_at_op = -1;
    endtask

    // One request end to end; expectations come from the request-level rules alone.
    task automatic run(input string tag, input bit op, input logic [23:0] a, input logic [8:0] len,
                       input int nb, input logic [7:0] sb, input logic [7:0] sf,
                       input int ext, input int ad, input bit poke);
        int page_end, n_rd, lat, n_bytes;
        bit rej, tmo, poked;
        clear_logs();
        n_busy = nb; stat_busy = sb; stat_fin = sf; extra = ext; ack_dly = ad;
        page_end = int'(a[7:0]) + int'(len);
        rej = !op && (len == 0 || len > 256 || page_end > 256);
        tmo = !rej && nb >= PMAX;
        n_rd = rej ? 0 : tmo ? PMAX : nb + 1;
        n_bytes = (!rej && !op) ? int'(len) : 0;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_op = op; i_req_addr = a; i_req_len = len;
        @(negedge clk);
        i_req_valid = 1'b0;
        chk({tag, "_ready_drop"}, o_req_ready, 0);
        lat = 1;
        poked = 0;
        while (!(o_done || o_err) && lat < 5000) begin
            if (poke && !poked && o_cmd_valid && o_cmd == C_RDSR) begin
                i_req_valid = 1'b1;
                poked = 1;
            end
            @(negedge clk);
            i_req_valid = 1'b0;
            lat++;
        end
        chk({tag, "_finished"}, lat < 5000, 1);
        if (rej) chk({tag, "_rej_latency"}, lat <= 2, 1);
        repeat (8) @(negedge clk);
        chk({tag, "_done_cnt"}, n_done, (!rej && !tmo) ? 1 : 0);
        chk({tag, "_err_cnt"}, n_err, (rej || tmo) ? 1 : 0);
        chk({tag, "_cmd_cnt"}, cmd_log.size(), rej ? 0 : 2 + n_rd);
        chk({tag, "_src_rd_cnt"}, n_src, n_bytes);
        chk({tag, "_byte_cnt"}, cap_log.size(), n_bytes);
        for (int i = 0; i < cap_log.size() && i < n_bytes; i++)
            chk($sformatf("%s_byte%0d", tag, i), cap_log[i], src_mem[i]);
        chk({tag, "_cmd_stable"}, unstable, 0);
        if (!rej && cmd_log.size() == 2 + n_rd) begin
            chk({tag, "_wren_cmd"}, cmd_log[0], C_WREN);
            chk({tag, "_wren_size"}, size_log[0], 0);
            chk({tag, "_op_cmd"}, cmd_log[1], op ? C_SE : C_PP);
            chk({tag, "_op_addr"}, addr_log[1], op ? {a[23:12], 12'h000} : a);
            chk({tag, "_op_size"}, size_log[1], op ? 0 : int'(len));
            chk({tag, "_status_before_poll"}, st_at_op, exp_status);
            for (int i = 2; i < cmd_log.size(); i++) begin
                chk($sformatf("%s_rdsr%0d_cmd", tag, i), cmd_log[i], C_RDSR);
                chk($sformatf("%s_rdsr%0d_size", tag, i), size_log[i], 1);
                chk($sformatf("%s_rdsr%0d_gap", tag, i), gap_log[i] >= PGAP, 1);
            end
        end
        if (!rej) exp_status = tmo ? sb : sf;
        chk({tag, "_status"}, o_status, exp_status);
        chk({tag, "_idle_ready"}, o_req_ready, 1);
        chk({tag, "_idle_busy"}, o_busy, 0);
    endtask

    initial begin
        int maxlen, nlen;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_req_ready, 1);
        chk("rst_ctrl_outs", {o_busy, o_done, o_err, o_cmd_valid, o_src_rd, o_cmd, o_status}, 0);
        chk("rst_data_outs", {o_byte_size, o_data_in}, 0);
        chk("rst_addr", o_addr, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) src_mem[i] = 8'(8'h35 + i);
        run("pp4", 0, 24'h112200, 9'd4, 0, 8'h01, 8'h00, 0, 20, 0);
        run("se", 1, 24'h112345, 9'd0, 3, 8'h01, 8'h00, 0, 20, 0);
        run("rej17", 0, 24'h1122F0, 9'd17, 0, 8'h01, 8'h00, 0, 20, 0);
        run("rej0", 0, 24'h001000, 9'd0, 0, 8'h01, 8'h00, 0, 20, 0);
        run("rej300", 0, 24'h001000, 9'd300, 0, 8'h01, 8'h00, 0, 20, 0);
        run("pp256", 0, 24'h000000, 9'd256, 0, 8'h01, 8'h00, 0, 20, 0);
        run("tmo", 1, 24'hABCDEF, 9'd0, 100, 8'h03, 8'h00, 0, 20, 0);

        clear_logs();
        n_busy = 0; stat_fin = 8'h00; extra = 0; ack_dly = 40;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_op = 1'b0; i_req_addr = 24'h000010; i_req_len = 9'd8;
        @(negedge clk);
        i_req_valid = 1'b0;
        for (int k = 0; k < 500 && n_src < 2; k++) @(negedge clk);
        chk("rst_mid_reached", n_src >= 2, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", o_req_ready, 1);
        chk("rst_mid_ctrl_outs", {o_busy, o_done, o_err, o_cmd_valid, o_src_rd, o_cmd, o_status}, 0);
        chk("rst_mid_data_outs", {o_byte_size, o_data_in}, 0);
        chk("rst_mid_addr", o_addr, 0);
        chk("rst_mid_no_pulse", n_done + n_err, 0);
        exp_status = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 0, 24'h000010, 9'd8, 1, 8'h01, 8'h00, 0, 20, 0);
        run("ignore", 0, 24'h3400A0, 9'd6, 1, 8'h01, 8'h00, 3, 10, 1);

        for (int r = 0; r < 6; r++) begin
            u1 = $urandom; u2 = $urandom; u3 = $urandom;
            for (int i = 0; i < 256; i++) src_mem[i] = 8'($urandom);
            maxlen = 256 - int'(u2[7:0]);
            nlen = (u1[2:1] == 2'd0) ? int'(u1[31:23]) : 1 + int'(u1[30:8]) % maxlen;
            run($sformatf("rnd%0d", r), u1[0], u2[23:0], 9'(nlen), int'(u3[1:0]) % 3,
                {u3[15:9], 1'b1}, {u3[23:17], 1'b0}, int'(u3[25:24]) % 3, 3 + int'(u3[30:26]) % 20, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/spi_flash_prog_seq.md
Name: spi_flash_prog_seq

Overview:
- Upstream sequencer for spi_flash_cmd. Turns one high-level request into the full command sequence: program a page (1–256 bytes) or erase a 4 KB sector.
- Sequence is Write-Enable, then the operation, then Read-Status polling until WIP clears.
- Drives spi_flash_cmd's cmd/addr/size/data ports and pulls program data from an upstream byte source.
- Reports done or error to the parameter-storage / upgrade logic above it.

Parameters:
- CMD_WREN, 4'd1, spi_flash_cmd code for Write Enable (06h).
- CMD_SE, 4'd6, code for Sector Erase (20h + addr).
- CMD_RDSR, 4'd3, code for Read Status Register.
- CMD_PP, 4'd9, code for Page Program (02h + addr + data).
- POLL_GAP, 16'd100, idle clocks between status reads.
- POLL_MAX, 20'd100000, status reads before timeout error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  request strobe; sampled only while o_req_ready=1
- o_req_ready  out  1  high in IDLE only
- i_req_op  in  1  0=page program, 1=sector erase
- i_req_addr  in  24  flash byte address
- i_req_len  in  9  program byte count, 1..256; ignored for erase
- o_src_rd  out  1  read strobe to byte source (1-cycle read latency)
- i_src_data  in  8  byte from source
- o_busy  out  1  high whenever not IDLE
- o_done  out  1  1-cycle pulse: operation finished OK
- o_err  out  1  1-cycle pulse: rejected or timed out
- o_status  out  8  last status byte read
- o_cmd  out  4  to spi_flash_cmd i_cmd
- o_cmd_valid  out  1  to spi_flash_cmd i_cmd_valid
- i_cmd_ack  in  1  from spi_flash_cmd o_cmd_ack (1-cycle, command complete)
- o_addr  out  24  to spi_flash_cmd i_addr
- o_byte_size  out  9  to spi_flash_cmd i_byte_size
- i_data_req  in  1  from spi_flash_cmd o_data_req
- o_data_in  out  8  to spi_flash_cmd i_data_in
- i_data_out  in  8  from spi_flash_cmd o_data_out
- i_data_valid  in  1  from spi_flash_cmd o_data_valid

Behaviour:
- Reset state: all outputs 0 except o_req_ready=1. FSM in IDLE. Counters and request latches cleared. Reset mid-sequence abandons the flash op immediately; no done/err pulse.
- States: IDLE, WREN, OP, GAP, RDSR, CHECK, DONE, ERR.
- IDLE:
  - On i_req_valid, latch op, addr and len. o_req_ready falls next cycle.
  - Reject when op=0 and (len==0, len>256, or addr[7:0]+len>256); go to ERR.
  - Otherwise go to WREN.
- Command handshake:
  - In each command state, o_cmd, o_addr, o_byte_size and o_cmd_valid=1 are registered on state entry.
  - They are held stable until the cycle i_cmd_ack=1. o_cmd_valid drops the following cycle, and the FSM advances then.
  - A new command is never asserted in the cycle after ack (o_cmd_valid low ≥1 cycle).
- WREN: cmd=CMD_WREN, byte_size=0. On ack go to OP.
- OP:
  - Erase: cmd=CMD_SE, addr={addr[23:12],12'h0}, size 0.
  - Program: cmd=CMD_PP, addr=latched addr, byte_size=len.
  - On ack, clear poll count and go to GAP.
- Program data path: o_src_rd = i_data_req while in OP with op=0, else 0. o_data_in = i_src_data (the source presents the byte the cycle after o_src_rd). Exactly len source reads per program op; extra i_data_req pulses beyond len are ignored (no o_src_rd).
- GAP: count POLL_GAP cycles, then go to RDSR.
- RDSR:
  - cmd=CMD_RDSR, byte_size=1.
  - On i_data_valid, capture i_data_out into o_status.
  - On ack, increment the poll count and go to CHECK.
- CHECK:
  - status[0]==0: go to DONE.
  - Else if poll count == POLL_MAX: go to ERR.
  - Else go to GAP.
- DONE / ERR: pulse o_done / o_err for 1 cycle, then go to IDLE.
- Arithmetic:
  - addr[7:0]+len is computed at 10 bits (no wrap). len=256 with addr[7:0]=0 is legal.
  - Poll count is 20-bit saturating.
- i_req_valid while busy is ignored. i_data_valid outside RDSR is ignored.

Test Plan:
- Program addr=24'h112200, len=4, source bytes 35h..38h; stub acks each cmd after 20 cycles; status 00h on first read → cmd sequence 1,9,3; o_byte_size 0,4,1; exactly 4 o_src_rd; o_data_in 35h,36h,37h,38h; o_done one pulse; o_err never.
- Erase addr=24'h112345; status 01h for 3 reads, then 00h → o_addr=24'h112000 on SE; 4 RDSR commands, each preceded by 100 idle cycles; o_status=00h; o_done.
- Program addr=24'h1122F0, len=17 → o_err pulse 2 cycles after request; no o_cmd_valid ever. Also len=0 → o_err. Also addr=24'h000000, len=256 → accepted, byte_size=256.
- Timeout with POLL_MAX=5: status stuck at 03h → exactly 5 RDSR commands, then o_err; o_status=03h.
- Assert rst_n low during OP after 2 data_req pulses → all outputs 0 and o_req_ready=1 immediately; a fresh program request afterwards completes normally.
- Pulse i_req_valid during RDSR and stub extra i_data_req in OP beyond len → both ignored; no second sequence, o_src_rd count still equals len.
